// File: rtl/cv_bg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cv_bg_pkg
// Brief   : Shared constants and types for the BG tile-map fetcher.
// Revision: 1.0 - initial release
// ============================================================================
package cv_bg_pkg;

  // Map geometry: 64x64 entries per bank, 16x16-pixel tiles, 1024x1024 plane.
  localparam int         MAP_COLS   = 64;
  localparam int         MAP_ROWS   = 64;
  localparam int         TILE_SHIFT = 4;
  localparam logic [9:0] PLANE_MASK = 10'h3FF;

  // One map entry as handed to the pattern fetch stage.
  typedef struct packed {
    logic [9:0] code;
    logic [3:0] fine_y;
    logic [3:0] fine_x;
    logic       first;
    logic       last;
  } bg_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } bg_state_t;

  // Build an entry; the fine-x skip only applies to the first tile of a line.
  function automatic bg_entry_t make_entry(input logic [9:0] code,
                                           input logic [3:0] fy,
                                           input logic [3:0] fx,
                                           input logic       first,
                                           input logic       last);
    bg_entry_t e;
    e.code   = code;
    e.fine_y = fy;
    e.fine_x = first ? fx : 4'd0;
    e.first  = first;
    e.last   = last;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cv_bg_fifo2.sv
`default_nettype none
// ============================================================================
// Module  : cv_bg_fifo2
// Brief   : Two-entry FIFO of bg_entry_t. The head entry sits in a register
//           so the downstream sees registered outputs. Flush empties it.
// Revision: 1.0 - initial release
// ============================================================================
module cv_bg_fifo2
  import cv_bg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  bg_entry_t  din,
  output bg_entry_t  dout,
  output logic [1:0] count,
  output logic       valid
);

  bg_entry_t slot0;
  bg_entry_t slot1;
  logic [1:0] cnt;

  // Storage and occupancy; slot0 is always the head of the queue.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= din;
          else             slot1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the incoming entry goes behind whatever remains.
          if (cnt == 2'd2) begin
            slot0 <= slot1;
            slot1 <= din;
          end else begin
            slot0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = slot0;
  assign count = cnt;
  assign valid = (cnt != 2'd0);

endmodule
`default_nettype wire

// File: rtl/cv_bg_fetch.sv
`default_nettype none
// ============================================================================
// Module  : cv_bg_fetch
// Brief   : Per-scanline BG tile-map fetcher. Latches scroll/bank on
//           line_start, issues TILES_PER_LINE map reads with a two-credit
//           limit, and streams tagged entries over valid/ready.
//           Optional: define CV_BG_FETCH_OVERRUN_EN for a sticky 'overrun'
//           output flagging a line_start that aborted a busy line.
//           TILES_PER_LINE legal range is 1..64.
// Revision: 1.0 - initial release
// ============================================================================
module cv_bg_fetch
  import cv_bg_pkg::*;
#(
  parameter int TILES_PER_LINE = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  input  logic [9:0]  r_yoffset,
  input  logic [9:0]  r_xoffset,
  input  logic [1:0]  r_bank,
  output logic [13:0] t_addr,
  output logic        t_ren,
  input  logic [9:0]  t_dout,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [9:0]  o_code,
  output logic [3:0]  o_fine_y,
  output logic [3:0]  o_fine_x,
  output logic        o_first,
  output logic        o_last,
`ifdef CV_BG_FETCH_OVERRUN_EN
  output logic        overrun,
`endif
  output logic        busy
);

  localparam logic [6:0] TPL = 7'(TILES_PER_LINE);

  bg_state_t   state;
  logic [1:0]  bank_q;
  logic [5:0]  row_q;
  logic [5:0]  col_q;
  logic [3:0]  fy_q;
  logic [3:0]  fx_q;
  logic [6:0]  remaining;
  logic [13:0] addr_q;
  logic        in_flight;
  logic        fl_first;
  logic        fl_last;

  logic [9:0]  ys;
  logic [1:0]  fifo_count;
  logic        fifo_valid;
  bg_entry_t   head;
  bg_entry_t   din;
  logic        final_xfer;
  logic        abort;
  logic        pop;
  logic        push;
  logic [2:0]  occ;
  logic        issue;
  logic [13:0] cur_addr;

  assign ys       = (line_y + r_yoffset) & PLANE_MASK;
  assign cur_addr = {bank_q, row_q, col_q};

  // A line_start that coincides with the hand-off of the previous line's
  // last entry lets that transfer finish; any other line_start while busy
  // abandons the current line and suppresses the transfer in that cycle.
  assign busy       = (state == ST_FETCH) | in_flight | (fifo_count != 2'd0);
  assign final_xfer = fifo_valid & o_ready & head.last;
  assign abort      = line_start & busy & ~final_xfer;
  assign pop        = fifo_valid & o_ready & ~abort;
  assign push       = in_flight & ~abort;

  // Credit: entries buffered plus the one in flight, minus any leaving now,
  // must leave room for the read being issued.
  assign occ   = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
  assign issue = (state == ST_FETCH) & ~line_start & (remaining != 7'd0) & (occ < 3'd2);

  assign t_ren  = issue;
  assign t_addr = issue ? cur_addr : addr_q;

  assign din = make_entry(t_dout, fy_q, fx_q, fl_first, fl_last);

  cv_bg_fifo2 u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (abort),
    .din     (din),
    .dout    (head),
    .count   (fifo_count),
    .valid   (fifo_valid)
  );

  assign o_valid  = fifo_valid;
  assign o_code   = head.code;
  assign o_fine_y = head.fine_y;
  assign o_fine_x = head.fine_x;
  assign o_first  = head.first;
  assign o_last   = head.last;

  // Line FSM: latch geometry on line_start, then step the column per issued read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bank_q    <= 2'd0;
      row_q     <= 6'd0;
      col_q     <= 6'd0;
      fy_q      <= 4'd0;
      fx_q      <= 4'd0;
      remaining <= 7'd0;
      addr_q    <= 14'd0;
      in_flight <= 1'b0;
      fl_first  <= 1'b0;
      fl_last   <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        addr_q    <= cur_addr;
        col_q     <= col_q + 6'd1;
        remaining <= remaining - 7'd1;
        fl_first  <= (remaining == TPL);
        fl_last   <= (remaining == 7'd1);
        if (remaining == 7'd1) state <= ST_IDLE;
      end
      if (line_start) begin
        state     <= ST_FETCH;
        bank_q    <= r_bank;
        row_q     <= ys[9:TILE_SHIFT];
        fy_q      <= ys[TILE_SHIFT-1:0];
        col_q     <= r_xoffset[9:TILE_SHIFT];
        fx_q      <= r_xoffset[TILE_SHIFT-1:0];
        remaining <= TPL;
      end
    end
  end

`ifdef CV_BG_FETCH_OVERRUN_EN
  // Sticky overrun: set by an aborting line_start, cleared once a line completes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (abort) begin
      overrun <= 1'b1;
    end else if (pop && head.last) begin
      overrun <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire
